// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU arbiter slice.
//   state_e     : arbiter sequencing states
//   opcodes     : ALU opcode encodings (passed through to the ALU unchecked)
//   latencies   : ALU register latency and end-to-end response latency
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        CAPT = 2'd2
    } state_e;

    localparam logic [3:0] ADD  = 4'b0010;
    localparam logic [3:0] CBZ  = 4'b0111;
    localparam logic [3:0] SUB  = 4'b1010;
    localparam logic [3:0] AND  = 4'b0110;
    localparam logic [3:0] OR   = 4'b0100;
    localparam logic [3:0] XOR  = 4'b1001;
    localparam logic [3:0] NOR  = 4'b0101;
    localparam logic [3:0] NAND = 4'b1100;
    localparam logic [3:0] MOV  = 4'b1101;

    // ALU registers its result one edge after operands are presented.
    localparam int unsigned ALU_LATENCY = 1;
    // Handshake edge to rsp_valid cycle.
    localparam int unsigned RSP_LATENCY = 3;

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of requester, ALU and response signals around the ALU arbiter.
//   req_*  : per-requester valid/ready handshake and packed payloads
//   alu_*  : operands/opcode to the ALU, result/carry/zero back
//   rsp_*  : one-hot response pulse plus result, carry and zero flag
// Modports: master = requesters + ALU side, slave = the arbiter.
interface alu_arbiter_if #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned OP_W    = 4
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*OP_W-1:0]  req_opcode;
    logic [NUM_REQ*WIDTH-1:0] req_in_one;
    logic [NUM_REQ*WIDTH-1:0] req_in_two;

    logic [OP_W-1:0]          alu_opcode;
    logic [WIDTH-1:0]         alu_in_one;
    logic [WIDTH-1:0]         alu_in_two;
    logic [WIDTH-1:0]         alu_result;
    logic                     alu_carry;
    logic                     alu_zero;

    logic [NUM_REQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]         rsp_result;
    logic                     rsp_carry;
    logic                     rsp_zero;

    modport master (
        output req_valid, req_opcode, req_in_one, req_in_two,
        output alu_result, alu_carry, alu_zero,
        input  req_ready, alu_opcode, alu_in_one, alu_in_two,
        input  rsp_valid, rsp_result, rsp_carry, rsp_zero
    );

    modport slave (
        input  req_valid, req_opcode, req_in_one, req_in_two,
        input  alu_result, alu_carry, alu_zero,
        output req_ready, alu_opcode, alu_in_one, alu_in_two,
        output rsp_valid, rsp_result, rsp_carry, rsp_zero
    );

endinterface

// File: rtl/alu_arbiter_rr_arbiter.sv
// Request arbiter producing a one-hot grant.
// Build option ALU_ARB_FIXED_PRIO_EN: when defined, fixed priority (lowest
// index wins) with no pointer; otherwise round-robin starting at the
// requester after the last grantee.
//   clock, reset : clock and synchronous active-high reset
//   req_i        : request vector
//   en_i         : grant enable (arbiter idle and not in reset)
//   upd_i        : a grant was taken this cycle, advance the pointer
//   gnt_c_o      : combinational one-hot grant, zero when none
module rr_arbiter
    import alu_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               en_i,
    input  logic               upd_i,
    output logic [NUM_REQ-1:0] gnt_c_o
);

`ifdef ALU_ARB_FIXED_PRIO_EN

    logic [NUM_REQ-1:0] gnt_c;
    logic               found_c;
    logic               unused_c;

    assign unused_c = ^{clock, reset, upd_i};

    // Lowest index wins.
    always_comb begin
        gnt_c   = '0;
        found_c = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (en_i && !found_c && req_i[k]) begin
                gnt_c[k] = 1'b1;
                found_c  = 1'b1;
            end
        end
    end

    assign gnt_c_o = gnt_c;

`else

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W-1:0]   ptr_d;
    logic [NUM_REQ-1:0] gnt_c;
    logic [PTR_W:0]     sum_c;
    logic [PTR_W-1:0]   idx_c;
    logic               found_c;

    // Scan from ptr_q upward with wrap; first pending request wins and the
    // pointer is set to the requester after it.
    always_comb begin
        gnt_c   = '0;
        ptr_d   = ptr_q;
        sum_c   = '0;
        idx_c   = '0;
        found_c = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum_c = {1'b0, ptr_q} + (PTR_W+1)'(k);
            if (sum_c >= (PTR_W+1)'(NUM_REQ)) begin
                sum_c = sum_c - (PTR_W+1)'(NUM_REQ);
            end
            idx_c = sum_c[PTR_W-1:0];
            if (en_i && !found_c && req_i[idx_c]) begin
                gnt_c[idx_c] = 1'b1;
                found_c      = 1'b1;
                ptr_d        = (idx_c == PTR_W'(NUM_REQ - 1)) ? '0 : idx_c + 1'b1;
            end
        end
        if (!upd_i) begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign gnt_c_o = gnt_c;

`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one clocked ALU between NUM_REQ requesters, one op in flight.
// Sequence: IDLE (grant, register operands) -> EXEC (ALU latches, capture
// zero flag) -> CAPT (register result/carry, pulse rsp_valid) -> IDLE.
// Build option ALU_ARB_FIXED_PRIO_EN selects fixed priority instead of
// round-robin inside rr_arbiter.
//   clock, reset : clock and synchronous active-high reset
//   bus          : alu_arbiter_if slave modport (requests, ALU, responses)
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned OP_W    = 4
) (
    input  logic         clock,
    input  logic         reset,
    alu_arbiter_if.slave bus
);

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] owner_q, owner_d;
    logic [OP_W-1:0]    opc_q, opc_d;
    logic [WIDTH-1:0]   in_one_q, in_one_d;
    logic [WIDTH-1:0]   in_two_q, in_two_d;
    logic               zero_q, zero_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]   rsp_result_q, rsp_result_d;
    logic               rsp_carry_q, rsp_carry_d;
    logic               rsp_zero_q, rsp_zero_d;

    logic [NUM_REQ-1:0] gnt_c;
    logic               arb_en_c;
    logic [OP_W-1:0]    sel_opc_c;
    logic [WIDTH-1:0]   sel_one_c;
    logic [WIDTH-1:0]   sel_two_c;

    // Grants only while idle; reset suppresses a same-cycle grant.
    assign arb_en_c = (state_q == IDLE) && !reset;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clock   (clock),
        .reset   (reset),
        .req_i   (bus.req_valid),
        .en_i    (arb_en_c),
        .upd_i   (|gnt_c),
        .gnt_c_o (gnt_c)
    );

    assign bus.req_ready = gnt_c;

    // One-hot AND-OR mux of the granted requester's payload.
    always_comb begin
        sel_opc_c = '0;
        sel_one_c = '0;
        sel_two_c = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_c[i]) begin
                sel_opc_c = sel_opc_c | bus.req_opcode[i*OP_W +: OP_W];
                sel_one_c = sel_one_c | bus.req_in_one[i*WIDTH +: WIDTH];
                sel_two_c = sel_two_c | bus.req_in_two[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        opc_d        = opc_q;
        in_one_d     = in_one_q;
        in_two_d     = in_two_q;
        zero_d       = zero_q;
        rsp_valid_d  = '0;
        rsp_result_d = rsp_result_q;
        rsp_carry_d  = rsp_carry_q;
        rsp_zero_d   = rsp_zero_q;
        case (state_q)
            IDLE: begin
                if (|gnt_c) begin
                    opc_d    = sel_opc_c;
                    in_one_d = sel_one_c;
                    in_two_d = sel_two_c;
                    owner_d  = gnt_c;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                // alu_zero is combinational on the stable alu_in_two.
                zero_d  = bus.alu_zero;
                state_d = CAPT;
            end
            CAPT: begin
                // ALU operands still held, so its re-evaluation is a no-op.
                rsp_result_d = bus.alu_result;
                rsp_carry_d  = bus.alu_carry;
                rsp_zero_d   = zero_q;
                rsp_valid_d  = owner_q;
                opc_d        = '0;
                in_one_d     = '0;
                in_two_d     = '0;
                owner_d      = '0;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            opc_q        <= '0;
            in_one_q     <= '0;
            in_two_q     <= '0;
            zero_q       <= 1'b0;
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
            rsp_carry_q  <= 1'b0;
            rsp_zero_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            opc_q        <= opc_d;
            in_one_q     <= in_one_d;
            in_two_q     <= in_two_d;
            zero_q       <= zero_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_carry_q  <= rsp_carry_d;
            rsp_zero_q   <= rsp_zero_d;
        end
    end

    assign bus.alu_opcode = opc_q;
    assign bus.alu_in_one = in_one_q;
    assign bus.alu_in_two = in_two_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_carry  = rsp_carry_q;
    assign bus.rsp_zero   = rsp_zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a simple registered ALU model.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned WIDTH   = 32;
    localparam int unsigned OP_W    = 4;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    alu_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .OP_W(OP_W)) bus ();

    alu_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .OP_W(OP_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ALU model: result/carry registered, zero flag combinational on inTwo.
    always @(posedge clock) begin
        case (bus.alu_opcode)
            ADD:  {bus.alu_carry, bus.alu_result} <= {1'b0, bus.alu_in_one} + {1'b0, bus.alu_in_two};
            SUB:  begin bus.alu_result <= bus.alu_in_one - bus.alu_in_two; bus.alu_carry <= (bus.alu_in_one < bus.alu_in_two); end
            AND:  begin bus.alu_result <= bus.alu_in_one & bus.alu_in_two; bus.alu_carry <= 1'b0; end
            OR:   begin bus.alu_result <= bus.alu_in_one | bus.alu_in_two; bus.alu_carry <= 1'b0; end
            XOR:  begin bus.alu_result <= bus.alu_in_one ^ bus.alu_in_two; bus.alu_carry <= 1'b0; end
            NOR:  begin bus.alu_result <= ~(bus.alu_in_one | bus.alu_in_two); bus.alu_carry <= 1'b0; end
            NAND: begin bus.alu_result <= ~(bus.alu_in_one & bus.alu_in_two); bus.alu_carry <= 1'b0; end
            MOV:  begin bus.alu_result <= bus.alu_in_two; bus.alu_carry <= 1'b0; end
            CBZ:  begin bus.alu_result <= bus.alu_in_one; bus.alu_carry <= 1'b0; end
            default: begin bus.alu_result <= '0; bus.alu_carry <= 1'b0; end
        endcase
    end

    assign bus.alu_zero = (bus.alu_in_two == '0);

    task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.req_valid[i]                = 1'b1;
        bus.req_opcode[i*OP_W +: OP_W]  = op;
        bus.req_in_one[i*WIDTH +: WIDTH] = a;
        bus.req_in_two[i*WIDTH +: WIDTH] = b;
    endtask

    task automatic clr_req(input int i);
        bus.req_valid[i] = 1'b0;
    endtask

    // Issue one request from an idle arbiter and wait (bounded) for its response.
    task automatic do_op(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [1:0] rdy, output int lat, output logic [1:0] rv,
                         output logic [31:0] res, output logic c, output logic z);
        @(negedge clock);
        set_req(i, op, a, b);
        #1;
        rdy = bus.req_ready;
        lat = 0; rv = '0; res = '0; c = 1'b0; z = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            if (k == 1) clr_req(i);
            if (bus.rsp_valid !== '0) begin
                lat = k; rv = bus.rsp_valid; res = bus.rsp_result; c = bus.rsp_carry; z = bus.rsp_zero;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_req(0, ADD, 32'd1, 32'd1);
        set_req(1, ADD, 32'd2, 32'd2);
        repeat (2) @(negedge clock);
        #1;
        checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b expected 00", bus.req_ready); end
        checks++; if (bus.alu_opcode !== 4'h0) begin errors++; $display("FAIL reset_alu_opcode: got %h expected 0", bus.alu_opcode); end
        checks++; if (bus.alu_in_one !== 32'h0 || bus.alu_in_two !== 32'h0) begin errors++; $display("FAIL reset_alu_in: got %h/%h expected 0/0", bus.alu_in_one, bus.alu_in_two); end
        checks++; if (bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 00", bus.rsp_valid); end
        checks++; if ({bus.rsp_result, bus.rsp_carry, bus.rsp_zero} !== 34'h0) begin errors++; $display("FAIL reset_rsp: got %h %b %b expected 0 0 0", bus.rsp_result, bus.rsp_carry, bus.rsp_zero); end
        clr_req(0);
        clr_req(1);
        reset = 1'b0;
    endtask

    task automatic test_single();
        logic [1:0] rdy, rv; int lat; logic [31:0] res; logic c, z;
        do_op(0, ADD, 32'd5, 32'd7, rdy, lat, rv, res, c, z);
        checks++; if (rdy !== 2'b01) begin errors++; $display("FAIL single_ready: got %b expected 01", rdy); end
        checks++; if (lat != 3) begin errors++; $display("FAIL single_latency: got %0d expected 3", lat); end
        checks++; if (rv !== 2'b01) begin errors++; $display("FAIL single_rsp_valid: got %b expected 01", rv); end
        checks++; if ({res, c, z} !== {32'd12, 1'b0, 1'b0}) begin errors++; $display("FAIL single_result: got %0d c%b z%b expected 12 c0 z0", res, c, z); end
        checks++; if (bus.alu_opcode !== 4'h0 || bus.alu_in_one !== 32'h0) begin errors++; $display("FAIL single_alu_idle: got %h %h expected 0 0", bus.alu_opcode, bus.alu_in_one); end
        @(negedge clock);
        checks++; if (bus.rsp_valid !== 2'b00 || bus.rsp_result !== 32'd12) begin errors++; $display("FAIL single_hold: got %b %0d expected 00 12", bus.rsp_valid, bus.rsp_result); end
    endtask

    task automatic test_carry_zero();
        logic [1:0] rdy, rv; int lat; logic [31:0] res; logic c, z;
        do_op(1, ADD, 32'hFFFF_FFFF, 32'd1, rdy, lat, rv, res, c, z);
        checks++; if (rdy !== 2'b10 || rv !== 2'b10) begin errors++; $display("FAIL carry_owner: got rdy %b rsp %b expected 10 10", rdy, rv); end
        checks++; if ({res, c, z} !== {32'd0, 1'b1, 1'b0}) begin errors++; $display("FAIL carry_result: got %h c%b z%b expected 0 c1 z0", res, c, z); end
        do_op(0, SUB, 32'd9, 32'd0, rdy, lat, rv, res, c, z);
        checks++; if (rv !== 2'b01) begin errors++; $display("FAIL zero_owner: got %b expected 01", rv); end
        checks++; if ({res, c, z} !== {32'd9, 1'b0, 1'b1}) begin errors++; $display("FAIL zero_result: got %0d c%b z%b expected 9 c0 z1", res, c, z); end
    endtask

    // Both requesters held valid; last grant was requester 0, so round-robin starts at 1.
    task automatic test_contention();
        int seq [5];
        logic [31:0] res_exp [2];
        logic [1:0] exp_rdy, exp_rv;
`ifdef ALU_ARB_FIXED_PRIO_EN
        seq = '{0, 0, 0, 0, 0};
`else
        seq = '{1, 0, 1, 0, 1};
`endif
        res_exp[0] = 32'd3;
        res_exp[1] = 32'd30;
        @(negedge clock);
        set_req(0, ADD, 32'd1, 32'd2);
        set_req(1, ADD, 32'd10, 32'd20);
        for (int cyc = 0; cyc <= 12; cyc++) begin
            if (cyc > 0) @(negedge clock);
            #1;
            exp_rdy = (cyc % 3 == 0) ? (2'b01 << seq[cyc/3]) : 2'b00;
            exp_rv  = (cyc >= 3 && cyc % 3 == 0) ? (2'b01 << seq[cyc/3 - 1]) : 2'b00;
            checks++; if (bus.req_ready !== exp_rdy) begin errors++; $display("FAIL contention_ready c%0d: got %b expected %b", cyc, bus.req_ready, exp_rdy); end
            checks++; if (bus.rsp_valid !== exp_rv) begin errors++; $display("FAIL contention_rsp_valid c%0d: got %b expected %b", cyc, bus.rsp_valid, exp_rv); end
            if (exp_rv != 2'b00) begin
                checks++; if (bus.rsp_result !== res_exp[seq[cyc/3 - 1]]) begin errors++; $display("FAIL contention_result c%0d: got %0d expected %0d", cyc, bus.rsp_result, res_exp[seq[cyc/3 - 1]]); end
            end
        end
        // Withdraw before the edge so the last grant is not taken.
        clr_req(0);
        clr_req(1);
    endtask

    task automatic test_back_to_back();
        @(negedge clock);
        set_req(0, ADD, 32'd100, 32'd23);
        #1;
        checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL b2b_ready0: got %b expected 01", bus.req_ready); end
        @(negedge clock);
        clr_req(0);
        set_req(1, XOR, 32'hA5A5_0000, 32'h0000_5A5A);
        #1;
        checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL b2b_busy_ready: got %b expected 00", bus.req_ready); end
        @(negedge clock);
        #1;
        checks++; if (bus.req_ready !== 2'b00 || bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL b2b_capt: got rdy %b rsp %b expected 00 00", bus.req_ready, bus.rsp_valid); end
        @(negedge clock);
        #1;
        checks++; if (bus.rsp_valid !== 2'b01 || bus.rsp_result !== 32'd123) begin errors++; $display("FAIL b2b_rsp0: got %b %0d expected 01 123", bus.rsp_valid, bus.rsp_result); end
        checks++; if (bus.req_ready !== 2'b10) begin errors++; $display("FAIL b2b_same_cycle_grant: got %b expected 10", bus.req_ready); end
        @(negedge clock);
        clr_req(1);
        #1;
        checks++; if (bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL b2b_pulse: got %b expected 00", bus.rsp_valid); end
        repeat (2) @(negedge clock);
        #1;
        checks++; if (bus.rsp_valid !== 2'b10 || bus.rsp_result !== 32'hA5A5_5A5A || bus.rsp_carry !== 1'b0) begin errors++; $display("FAIL b2b_rsp1: got %b %h c%b expected 10 a5a55a5a c0", bus.rsp_valid, bus.rsp_result, bus.rsp_carry); end
    endtask

    task automatic test_reset_mid();
        @(negedge clock);
        set_req(0, ADD, 32'd3, 32'd4);
        #1;
        checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL rstmid_ready: got %b expected 01", bus.req_ready); end
        @(negedge clock);
        clr_req(0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks++; if (bus.alu_opcode !== 4'h0 || bus.alu_in_one !== 32'h0 || bus.alu_in_two !== 32'h0) begin errors++; $display("FAIL rstmid_alu: got %h %h %h expected 0 0 0", bus.alu_opcode, bus.alu_in_one, bus.alu_in_two); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            checks++; if (bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL rstmid_no_rsp c%0d: got %b expected 00", k, bus.rsp_valid); end
        end
        // Pointer was 1 before reset; after reset requester 0 must win.
        set_req(0, SUB, 32'd50, 32'd8);
        set_req(1, ADD, 32'd1, 32'd1);
        #1;
        checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL rstmid_ptr: got %b expected 01", bus.req_ready); end
        @(negedge clock);
        clr_req(0);
        clr_req(1);
        repeat (2) @(negedge clock);
        #1;
        checks++; if (bus.rsp_valid !== 2'b01 || bus.rsp_result !== 32'd42 || bus.rsp_zero !== 1'b0) begin errors++; $display("FAIL rstmid_rsp: got %b %0d z%b expected 01 42 z0", bus.rsp_valid, bus.rsp_result, bus.rsp_zero); end
    endtask

    task automatic test_opcodes();
        logic [1:0] rdy, rv; int lat; logic [31:0] res; logic c, z;
        do_op(0, 4'b1111, 32'h1234_5678, 32'd3, rdy, lat, rv, res, c, z);
        checks++; if (rv !== 2'b01 || {res, c} !== 33'h0) begin errors++; $display("FAIL undef_op: got %b %h c%b expected 01 0 c0", rv, res, c); end
        do_op(1, MOV, 32'h0, 32'hDEAD_BEEF, rdy, lat, rv, res, c, z);
        checks++; if (rv !== 2'b10 || res !== 32'hDEAD_BEEF || c !== 1'b0) begin errors++; $display("FAIL mov_op: got %b %h c%b expected 10 deadbeef c0", rv, res, c); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.req_valid  = '0;
        bus.req_opcode = '0;
        bus.req_in_one = '0;
        bus.req_in_two = '0;
        test_reset();
        test_single();
        test_carry_zero();
        test_contention();
        test_back_to_back();
        test_reset_mid();
        test_opcodes();
        repeat (2) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, expected run to complete");
        $fatal(1);
    end

endmodule
